// File: rtl/uart_result_serializer.sv
// uart_result_serializer: buffers result words and streams them LSB-byte-first to a UART transmitter
module uart_result_serializer #(
   parameter int         DATA_W      = 16,
   parameter int         FIFO_DEPTH  = 8,
   parameter int         FRAME_WORDS = 16,
   parameter bit         HDR_EN      = 1'b1,
   parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          frame_sync,
   output logic [7:0]                    tx_byte,
   output logic                          tx_send,
   input  logic                          tx_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NB = DATA_W / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = $clog2(FRAME_WORDS + 1);
   typedef enum logic [1:0] {IDLE, HDR, SEND, WAIT} state_t;
   state_t              state_q;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [AW:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]   shift_q;
   logic [BW-1:0]       idx_q;
   logic [CW-1:0]       wcnt_q;
   logic                sync_q, hdr_q, tx_send_q;
   logic [7:0]          tx_byte_q;
   logic                push, pop, sync_any;
   assign in_ready   = cnt_q != (AW+1)'(FIFO_DEPTH);
   assign push       = in_valid && in_ready;
   assign pop        = (state_q == IDLE) && (cnt_q != '0);
   assign cnt_d      = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign sync_any   = sync_q || frame_sync;
   assign tx_byte    = tx_byte_q;
   assign tx_send    = tx_send_q;
   assign busy       = (state_q != IDLE) || (cnt_q != '0);
   assign fifo_level = cnt_q;
   // word storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= in_data;
   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   // byte sequencer: HDR/SEND raise tx_send for one cycle, WAIT holds the byte until tx_done;
   // a done seen while tx_send is still high belongs to an older byte and is ignored
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         wcnt_q    <= '0;
         sync_q    <= 1'b0;
         hdr_q     <= 1'b0;
         tx_byte_q <= 8'h00;
         tx_send_q <= 1'b0;
      end else begin
         tx_send_q <= 1'b0;
         if (frame_sync) sync_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (sync_any) begin
                  wcnt_q <= '0;
                  sync_q <= 1'b0;
               end
               if (pop) begin
                  shift_q <= mem_q[rd_q];
                  idx_q   <= '0;
                  if (HDR_EN && (wcnt_q == '0 || sync_any)) begin
                     tx_byte_q <= HDR_BYTE;
                     hdr_q     <= 1'b1;
                     state_q   <= HDR;
                  end else begin
                     tx_byte_q <= mem_q[rd_q][7:0];
                     state_q   <= SEND;
                  end
               end
            end
            HDR, SEND: begin
               tx_send_q <= 1'b1;
               state_q   <= WAIT;
            end
            WAIT: if (tx_done && !tx_send_q) begin
               if (hdr_q) begin
                  hdr_q     <= 1'b0;
                  tx_byte_q <= shift_q[7:0];
                  state_q   <= SEND;
               end else if (idx_q != BW'(NB - 1)) begin
                  shift_q   <= shift_q >> 8;
                  idx_q     <= idx_q + 1'b1;
                  tx_byte_q <= 8'(shift_q >> 8);
                  state_q   <= SEND;
               end else begin
                  wcnt_q  <= (sync_any || wcnt_q == CW'(FRAME_WORDS - 1)) ? '0 : wcnt_q + 1'b1;
                  sync_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
endmodule
